// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-requester (IFU/LSU) arbiter for a single req/gnt memory port
//
// Optional feature macro: MEM_ARB_RR_EN (round-robin on contention; default is LSU-first).
//
// Ports:
//   clk_i, rst_i                      clock (rising edge), asynchronous active-low reset
//   ifu_req_i/ifu_addr_i              fetch request, held until ifu_gnt_o
//   ifu_gnt_o                         fetch accepted (combinational, IDLE only)
//   ifu_rvalid_o/ifu_rdata_o          fetch response pulse and held data
//   lsu_req_i/we/addr/wdata/be        load/store request, held until lsu_gnt_o
//   lsu_gnt_o                         load/store accepted (combinational, IDLE only)
//   lsu_rvalid_o/lsu_rdata_o          load data / store ack pulse and held data
//   mem_req_o/we/addr/wdata/be        registered memory request, held until mem_gnt_i
//   mem_gnt_i/mem_rvalid_i/mem_rdata_i memory accept, response valid and data
//   busy_o                            a transaction is outstanding
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                ifu_req_i,
  input  logic [ADDR_W-1:0]   ifu_addr_i,
  output logic                ifu_gnt_o,
  output logic                ifu_rvalid_o,
  output logic [DATA_W-1:0]   ifu_rdata_o,
  input  logic                lsu_req_i,
  input  logic                lsu_we_i,
  input  logic [ADDR_W-1:0]   lsu_addr_i,
  input  logic [DATA_W-1:0]   lsu_wdata_i,
  input  logic [DATA_W/8-1:0] lsu_be_i,
  output logic                lsu_gnt_o,
  output logic                lsu_rvalid_o,
  output logic [DATA_W-1:0]   lsu_rdata_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic [DATA_W/8-1:0] mem_be_o,
  input  logic                mem_gnt_i,
  input  logic                mem_rvalid_i,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  output logic                busy_o
);

  localparam int BE_W = DATA_W / 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              busy_q, busy_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [BE_W-1:0]   mem_be_q, mem_be_d;
  logic              owner_lsu_q, owner_lsu_d;
  logic              ifu_rvalid_q, ifu_rvalid_d;
  logic              lsu_rvalid_q, lsu_rvalid_d;
  logic [DATA_W-1:0] ifu_rdata_q, ifu_rdata_d;
  logic [DATA_W-1:0] lsu_rdata_q, lsu_rdata_d;

  logic idle_ok;
  logic lsu_first;
  logic lsu_win;
  logic ifu_win;
  logic done;

  // Grants are only offered in IDLE, and never while reset is held so the
  // handshake outputs read 0 immediately on reset assertion.
  assign idle_ok = (state_q == ST_IDLE) && rst_i;

`ifdef MEM_ARB_RR_EN
  logic last_lsu_q, last_lsu_d;

  // On contention the requester that did not win last time goes first.
  assign lsu_first = ~last_lsu_q;

  always_comb begin
    last_lsu_d = last_lsu_q;
    if (lsu_win || ifu_win) begin
      last_lsu_d = lsu_win;
    end
  end
`else
  assign lsu_first = 1'b1;
`endif

  assign lsu_win = idle_ok && lsu_req_i && (!ifu_req_i || lsu_first);
  assign ifu_win = idle_ok && ifu_req_i && !lsu_win;

  // A response completes either together with the memory accept or later in RESP;
  // rvalid in IDLE or in REQ without the accept never matches here.
  assign done = ((state_q == ST_REQ) && mem_gnt_i && mem_rvalid_i) ||
                ((state_q == ST_RESP) && mem_rvalid_i);

  always_comb begin
    state_d      = state_q;
    busy_d       = busy_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_be_d     = mem_be_q;
    owner_lsu_d  = owner_lsu_q;
    ifu_rvalid_d = 1'b0;
    lsu_rvalid_d = 1'b0;
    ifu_rdata_d  = ifu_rdata_q;
    lsu_rdata_d  = lsu_rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (lsu_win) begin
          state_d     = ST_REQ;
          busy_d      = 1'b1;
          mem_req_d   = 1'b1;
          owner_lsu_d = 1'b1;
          mem_addr_d  = lsu_addr_i;
          mem_we_d    = lsu_we_i;
          mem_wdata_d = lsu_wdata_i;
          // Loads always request the full word.
          mem_be_d    = lsu_we_i ? lsu_be_i : {BE_W{1'b1}};
        end else if (ifu_win) begin
          state_d     = ST_REQ;
          busy_d      = 1'b1;
          mem_req_d   = 1'b1;
          owner_lsu_d = 1'b0;
          mem_addr_d  = ifu_addr_i;
          mem_we_d    = 1'b0;
          mem_wdata_d = '0;
          mem_be_d    = {BE_W{1'b1}};
        end
      end
      ST_REQ: begin
        if (mem_gnt_i) begin
          mem_req_d = 1'b0;
          state_d   = ST_RESP;
        end
      end
      ST_RESP: begin
        mem_req_d = 1'b0;
      end
      default: begin
        state_d   = ST_IDLE;
        busy_d    = 1'b0;
        mem_req_d = 1'b0;
      end
    endcase

    if (done) begin
      state_d = ST_IDLE;
      busy_d  = 1'b0;
      if (owner_lsu_q) begin
        lsu_rvalid_d = 1'b1;
        lsu_rdata_d  = mem_rdata_i;
      end else begin
        ifu_rvalid_d = 1'b1;
        ifu_rdata_d  = mem_rdata_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= ST_IDLE;
      busy_q       <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_be_q     <= '0;
      owner_lsu_q  <= 1'b0;
      ifu_rvalid_q <= 1'b0;
      lsu_rvalid_q <= 1'b0;
      ifu_rdata_q  <= '0;
      lsu_rdata_q  <= '0;
`ifdef MEM_ARB_RR_EN
      last_lsu_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_be_q     <= mem_be_d;
      owner_lsu_q  <= owner_lsu_d;
      ifu_rvalid_q <= ifu_rvalid_d;
      lsu_rvalid_q <= lsu_rvalid_d;
      ifu_rdata_q  <= ifu_rdata_d;
      lsu_rdata_q  <= lsu_rdata_d;
`ifdef MEM_ARB_RR_EN
      last_lsu_q   <= last_lsu_d;
`endif
    end
  end

  assign ifu_gnt_o    = ifu_win;
  assign lsu_gnt_o    = lsu_win;
  assign ifu_rvalid_o = ifu_rvalid_q;
  assign lsu_rvalid_o = lsu_rvalid_q;
  assign ifu_rdata_o  = ifu_rdata_q;
  assign lsu_rdata_o  = lsu_rdata_q;
  assign mem_req_o    = mem_req_q;
  assign mem_we_o     = mem_we_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wdata_o  = mem_wdata_q;
  assign mem_be_o     = mem_be_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ifu_req = 1'b0;
  logic [31:0] ifu_addr = '0;
  logic        ifu_gnt, ifu_rvalid;
  logic [31:0] ifu_rdata;
  logic        lsu_req = 1'b0, lsu_we = 1'b0;
  logic [31:0] lsu_addr = '0, lsu_wdata = '0;
  logic [3:0]  lsu_be = '0;
  logic        lsu_gnt, lsu_rvalid;
  logic [31:0] lsu_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        busy;

  mem_port_arbiter dut (
    .clk_i(clk), .rst_i(rst_n),
    .ifu_req_i(ifu_req), .ifu_addr_i(ifu_addr), .ifu_gnt_o(ifu_gnt),
    .ifu_rvalid_o(ifu_rvalid), .ifu_rdata_o(ifu_rdata),
    .lsu_req_i(lsu_req), .lsu_we_i(lsu_we), .lsu_addr_i(lsu_addr),
    .lsu_wdata_i(lsu_wdata), .lsu_be_i(lsu_be), .lsu_gnt_o(lsu_gnt),
    .lsu_rvalid_o(lsu_rvalid), .lsu_rdata_o(lsu_rdata),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_be_o(mem_be),
    .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
    .busy_o(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: one outstanding transaction, its latched fields,
  // whether memory has accepted it, and per-requester response pulse/data.
  bit          m_busy, m_acc, m_owner_lsu, m_last_lsu, m_we;
  bit          m_ifu_pulse, m_lsu_pulse;
  logic [31:0] m_addr, m_wdata, m_ifu_rdata, m_lsu_rdata;
  logic [3:0]  m_be;
  bit          e_lsu_gnt, e_ifu_gnt, m_finish;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_busy = 0; m_acc = 0; m_owner_lsu = 0; m_last_lsu = 0; m_we = 0;
      m_ifu_pulse = 0; m_lsu_pulse = 0;
      m_addr = '0; m_wdata = '0; m_ifu_rdata = '0; m_lsu_rdata = '0; m_be = '0;
      e_lsu_gnt = 0; e_ifu_gnt = 0;
    end else begin
      e_lsu_gnt = !m_busy && lsu_req && (!ifu_req || !RR || !m_last_lsu);
      e_ifu_gnt = !m_busy && ifu_req && !e_lsu_gnt;
    end
    chk("ifu_gnt", ifu_gnt, e_ifu_gnt);
    chk("lsu_gnt", lsu_gnt, e_lsu_gnt);
    chk("mem_req", mem_req, m_busy && !m_acc);
    chk("busy", busy, m_busy);
    chk("mem_we", mem_we, m_we);
    chk("mem_addr", mem_addr, m_addr);
    chk("mem_wdata", mem_wdata, m_wdata);
    chk("mem_be", mem_be, m_be);
    chk("ifu_rvalid", ifu_rvalid, m_ifu_pulse);
    chk("lsu_rvalid", lsu_rvalid, m_lsu_pulse);
    chk("ifu_rdata", ifu_rdata, m_ifu_rdata);
    chk("lsu_rdata", lsu_rdata, m_lsu_rdata);
    if (rst_n) begin
      m_ifu_pulse = 0;
      m_lsu_pulse = 0;
      if (e_lsu_gnt || e_ifu_gnt) begin
        m_busy      = 1;
        m_acc       = 0;
        m_owner_lsu = e_lsu_gnt;
        m_last_lsu  = e_lsu_gnt;
        m_addr      = e_lsu_gnt ? lsu_addr : ifu_addr;
        m_we        = e_lsu_gnt && lsu_we;
        m_wdata     = e_lsu_gnt ? lsu_wdata : 32'h0;
        m_be        = m_we ? lsu_be : 4'hF;
      end else if (m_busy) begin
        m_finish = mem_rvalid && (m_acc || mem_gnt);
        if (mem_gnt) m_acc = 1;
        if (m_finish) begin
          m_busy = 0;
          if (m_owner_lsu) begin m_lsu_pulse = 1; m_lsu_rdata = mem_rdata; end
          else begin m_ifu_pulse = 1; m_ifu_rdata = mem_rdata; end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  bit exp_lsu_order[4];
  int pulses;

  initial begin
    exp_lsu_order = RR ? '{1'b1, 1'b0, 1'b1, 1'b0} : '{1'b1, 1'b1, 1'b1, 1'b1};

    // Reset state
    repeat (2) tick();
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_mem_req", mem_req, 1'b0);
    tick(); rst_n = 1'b1;

    // Single fetch, best-case memory
    tick(); ifu_req = 1; ifu_addr = 32'h100;
    @(negedge clk); chk("f_ifu_gnt", ifu_gnt, 1'b1); chk("f_lsu_gnt", lsu_gnt, 1'b0);
    tick(); ifu_req = 0; mem_gnt = 1;
    @(negedge clk); chk("f_mem_req", mem_req, 1'b1); chk("f_mem_addr", mem_addr, 32'h100);
    chk("f_mem_be", mem_be, 4'hF);
    tick(); mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'hDEADBEEF;
    tick(); mem_rvalid = 0;
    @(negedge clk); chk("f_ifu_rvalid", ifu_rvalid, 1'b1); chk("f_ifu_rdata", ifu_rdata, 32'hDEADBEEF);
    chk("f_lsu_rvalid", lsu_rvalid, 1'b0);

    // Contention: store wins, fetch granted when store completes
    tick(); ifu_req = 1; ifu_addr = 32'h300;
    lsu_req = 1; lsu_we = 1; lsu_addr = 32'h200; lsu_wdata = 32'h12345678; lsu_be = 4'hF;
    @(negedge clk); chk("c_lsu_gnt", lsu_gnt, 1'b1); chk("c_ifu_gnt", ifu_gnt, 1'b0);
    tick(); lsu_req = 0; mem_gnt = 1;
    @(negedge clk); chk("c_mem_we", mem_we, 1'b1); chk("c_mem_wdata", mem_wdata, 32'h12345678);
    chk("c_ifu_wait", ifu_gnt, 1'b0);
    tick(); mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'hAAAA5555;
    tick(); mem_rvalid = 0;
    @(negedge clk); chk("c_lsu_rvalid", lsu_rvalid, 1'b1); chk("c_ifu_gnt_after", ifu_gnt, 1'b1);
    // Zero-latency memory: gnt and rvalid together, response next cycle
    tick(); ifu_req = 0; mem_gnt = 1; mem_rvalid = 1; mem_rdata = 32'h0BADF00D;
    @(negedge clk); chk("z_mem_addr", mem_addr, 32'h300);
    tick(); mem_gnt = 0; mem_rvalid = 0;
    @(negedge clk); chk("z_ifu_rvalid", ifu_rvalid, 1'b1); chk("z_ifu_rdata", ifu_rdata, 32'h0BADF00D);
    chk("z_lsu_rdata_hold", lsu_rdata, 32'hAAAA5555);

    // Continuous contention for four transactions
    tick(); ifu_req = 1; ifu_addr = 32'h800; lsu_req = 1; lsu_we = 0; lsu_addr = 32'h700;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("order_lsu_gnt", lsu_gnt, exp_lsu_order[k]);
      chk("order_ifu_gnt", ifu_gnt, !exp_lsu_order[k]);
      tick(); mem_gnt = 1; mem_rvalid = 1; mem_rdata = 32'h3000 + k;
      if (k == 3) begin ifu_req = 0; lsu_req = 0; end
      tick(); mem_gnt = 0; mem_rvalid = 0;
    end

    // Wait states: gnt after 3 stall cycles, rvalid 2 cycles later, stray rvalid in REQ
    tick(); lsu_req = 1; lsu_we = 0; lsu_addr = 32'h400; lsu_be = 4'h3; lsu_wdata = 32'h55;
    @(negedge clk); chk("w_lsu_gnt", lsu_gnt, 1'b1);
    pulses = 0;
    for (int c = 1; c <= 7; c++) begin
      tick(); lsu_req = 0; mem_gnt = (c == 4); mem_rvalid = (c == 2 || c == 7);
      mem_rdata = (c == 2) ? 32'h00000BAD : 32'hC0FFEE01;
      @(negedge clk);
      if (c <= 4) begin
        chk("w_mem_req", mem_req, 1'b1); chk("w_mem_addr", mem_addr, 32'h400);
        chk("w_mem_be", mem_be, 4'hF); chk("w_mem_we", mem_we, 1'b0);
      end
      chk("w_busy", busy, 1'b1);
      pulses += int'(lsu_rvalid) + int'(ifu_rvalid);
    end
    tick(); mem_gnt = 0; mem_rvalid = 0;
    @(negedge clk); chk("w_lsu_rdata", lsu_rdata, 32'hC0FFEE01);
    pulses += int'(lsu_rvalid) + int'(ifu_rvalid);
    tick();
    @(negedge clk); pulses += int'(lsu_rvalid) + int'(ifu_rvalid);
    chk("w_pulse_count", pulses, 1);

    // Stray rvalid in IDLE
    tick(); mem_rvalid = 1; mem_rdata = 32'h99;
    tick();
    tick(); mem_rvalid = 0;
    @(negedge clk); chk("s_lsu_rvalid", lsu_rvalid, 1'b0); chk("s_ifu_rvalid", ifu_rvalid, 1'b0);
    chk("s_lsu_rdata", lsu_rdata, 32'hC0FFEE01); chk("s_busy", busy, 1'b0);

    // Reset while in RESP
    tick(); ifu_req = 1; ifu_addr = 32'h500;
    @(negedge clk); chk("r_ifu_gnt", ifu_gnt, 1'b1);
    tick(); ifu_req = 0; mem_gnt = 1;
    tick(); mem_gnt = 0;
    #2; rst_n = 0;
    #1;
    chk("r_busy", busy, 1'b0); chk("r_mem_req", mem_req, 1'b0);
    chk("r_mem_addr", mem_addr, 32'h0); chk("r_ifu_rdata", ifu_rdata, 32'h0);
    chk("r_mem_be", mem_be, 4'h0);
    tick(); rst_n = 1;
    tick(); mem_rvalid = 1; mem_rdata = 32'h77;
    tick(); mem_rvalid = 0;
    @(negedge clk); chk("r_no_ifu_rvalid", ifu_rvalid, 1'b0); chk("r_no_lsu_rvalid", lsu_rvalid, 1'b0);
    tick(); lsu_req = 1; lsu_we = 1; lsu_addr = 32'h600; lsu_wdata = 32'hCAFE0001; lsu_be = 4'h5;
    @(negedge clk); chk("r_lsu_gnt", lsu_gnt, 1'b1);
    tick(); lsu_req = 0; mem_gnt = 1;
    @(negedge clk); chk("r_mem_addr2", mem_addr, 32'h600); chk("r_mem_be2", mem_be, 4'h5);
    tick(); mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h1;
    tick(); mem_rvalid = 0;
    @(negedge clk); chk("r_lsu_rvalid", lsu_rvalid, 1'b1);
    repeat (2) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester memory arbiter that shares the processor's single memory port between the instruction-fetch unit (IFU) and the load/store unit (LSU). It sits between the pipeline front/back ends and the external memory interface. It accepts one transaction at a time, drives the memory request with a req/gnt handshake, waits for the response and routes it back to the owning requester. The grant policy is fixed-priority LSU-first, or round-robin when configured.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width; byte-enable width is DATA_W/8
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-low reset
- ifu_req_i  in  1  fetch request; held with ifu_addr_i until ifu_gnt_o
- ifu_addr_i  in  ADDR_W  fetch address
- ifu_gnt_o  out  1  fetch request accepted (combinational, IDLE only)
- ifu_rvalid_o  out  1  fetch response valid, one-cycle pulse
- ifu_rdata_o  out  DATA_W  fetch response data
- lsu_req_i  in  1  load/store request; held with its fields until lsu_gnt_o
- lsu_we_i  in  1  1 = store
- lsu_addr_i  in  ADDR_W  load/store address
- lsu_wdata_i  in  DATA_W  store data
- lsu_be_i  in  DATA_W/8  store byte enables
- lsu_gnt_o  out  1  load/store request accepted (combinational, IDLE only)
- lsu_rvalid_o  out  1  load data or store acknowledge, one-cycle pulse
- lsu_rdata_o  out  DATA_W  load data
- mem_req_o  out  1  memory request; held until mem_gnt_i
- mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o  out  1/ADDR_W/DATA_W/DATA_W/8  registered request fields
- mem_gnt_i  in  1  memory accepted the request
- mem_rvalid_i  in  1  memory response or write acknowledge valid
- mem_rdata_i  in  DATA_W  memory response data
- busy_o  out  1  state != IDLE

## Operation
- FSM states:
  - IDLE: if any req_i is high, select the winner. Assert the winner's gnt_o in the same cycle. Register addr/we/wdata/be and the owner. Go to REQ. If lsu_we_i=0, latch we=0 and be=all ones. A fetch always latches we=0 and be=all ones.
  - REQ: mem_req_o=1. On mem_gnt_i go to RESP. On mem_gnt_i together with mem_rvalid_i, complete immediately and go to IDLE.
  - RESP: mem_req_o=0. On mem_rvalid_i, register mem_rdata_i into the owner's rdata_o, pulse the owner's rvalid_o next cycle, and go to IDLE.
- Stores also complete on mem_rvalid_i. The rdata for a store is forwarded unchanged, and the LSU ignores it.
- Exactly one transaction is outstanding. The non-winner's gnt_o stays 0, and that requester keeps its request asserted.
- mem_rvalid_i in IDLE, or in REQ without mem_gnt_i, is ignored.
- mem_* request fields stay stable from entry into REQ until mem_gnt_i.
- rdata_o holds its last value between pulses. Only the owner's rvalid_o pulses.

## Timing
- Reset values: all gnt_o, rvalid_o, mem_req_o, mem_we_o and busy_o are 0. All data, address and byte-enable outputs are 0. State is IDLE. The round-robin pointer is IFU (next contention goes to the LSU).
- Reset asserted mid-transaction aborts it: outputs return to reset values immediately, and any later memory response is ignored.
- Best case: request and gnt in cycle 0, mem_req_o in cycle 1, mem_gnt_i in cycle 1, mem_rvalid_i in cycle 2, rvalid_o in cycle 3. A new grant is possible in cycle 3, so throughput is 1 transaction per 3 cycles.
- With mem_gnt_i and mem_rvalid_i in the same cycle (cycle 1), rvalid_o is in cycle 2 and the next grant is possible in cycle 2.
- Memory wait states stretch REQ and RESP without limit. There is no timeout.

## Configuration
- MEM_ARB_RR_EN defined: round-robin arbitration. On contention the requester not granted last wins. The last-winner register updates on every grant.
- MEM_ARB_RR_EN undefined: fixed priority. The LSU always wins contention, and the pointer logic is not compiled.

## Test plan
- Single fetch: ifu_req_i=1, addr 0x0000_0100, memory returns 0xDEAD_BEEF with gnt in cycle 1 and rvalid in cycle 2 -> ifu_gnt_o in cycle 0, mem_addr_o=0x100, ifu_rvalid_o in cycle 3 with ifu_rdata_o=0xDEAD_BEEF, lsu_rvalid_o stays 0.
- Contention, fixed priority: both requesters high, store addr 0x200, data 0x1234_5678, be 0xF -> lsu_gnt_o first with mem_we_o=1 and mem_wdata_o=0x1234_5678. The fetch is granted the cycle its store completes back to IDLE.
- Contention, MEM_ARB_RR_EN: both requesters high continuously for 4 transactions -> grant order LSU, IFU, LSU, IFU.
- Wait states: mem_gnt_i delayed 3 cycles, then rvalid delayed 2 cycles -> mem_req_o and the mem_* fields stay stable for 4 cycles, busy_o stays 1 throughout, and exactly one rvalid_o pulse occurs.
- Zero-latency memory (gnt and rvalid in the same cycle) and a stray rvalid in IDLE -> completion in cycle 2, and the stray pulse produces no rvalid_o.
- Reset asserted while in RESP -> all outputs 0 immediately. A mem_rvalid_i after reset release causes no rvalid_o, and the next request is granted normally.
